// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and the word-length encoding
// from the line control register, used by both the RX and TX controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_t;

  localparam int WLS_BASE = 5;

  function automatic logic [3:0] wls_bits(input wls_t wls);
    return 4'(WLS_BASE) + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rxd pad; resets to the idle-high
// line level so that reset release never looks like a start-bit edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic rxd,
  output logic rxd_sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxd_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: detects the start edge, samples each bit at the baud
// generator's mid-bit strobe, checks parity/framing/break and pushes to the RX FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              rxd,
  input  logic              rx_en,
  input  logic [1:0]        lcr_wls,
  input  logic              lcr_pen,
  input  logic              lcr_eps,
  input  logic              lcr_sp,
  input  logic              sample_edge,
  input  logic              rx_full,
  output logic              sample_clk_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_push,
  output logic              rx_pe,
  output logic              rx_fe,
  output logic              rx_bi,
  output logic              rx_oe,
  output logic              rx_busy
);

  // DATA_W must be at least the longest character (8 bits)
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_W);

  rx_state_t         state, state_nxt;
  logic              rxd_s, rxd_prev, fall;
  logic              edge_ok;
  logic              clr_nxt, push_nxt, oe_nxt;
  logic              start_frame, shift_en, par_en, stop_en;
  wls_t              frame_wls;
  logic              frame_pen, frame_eps, frame_sp;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt, cnt_inc, nbits;
  logic              par_bit, par_exp;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .pclk     (pclk),
    .presetn  (presetn),
    .rxd      (rxd),
    .rxd_sync (rxd_s)
  );

  assign fall    = rxd_prev & ~rxd_s;
  // a strobe coinciding with the timer restart belongs to the previous bit period
  assign edge_ok = sample_edge & ~sample_clk_clr;
  assign nbits   = CNT_W'(wls_bits(frame_wls));
  assign cnt_inc = bit_cnt + CNT_W'(1);
  assign par_exp = frame_sp ? ~frame_eps : (frame_eps ? ^shreg : ~^shreg);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clr_nxt     = 1'b0;
    push_nxt    = 1'b0;
    oe_nxt      = 1'b0;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    case (state)
      IDLE: if (rx_en && fall) begin
        state_nxt   = START;
        clr_nxt     = 1'b1;
        start_frame = 1'b1;
      end
      START: if (edge_ok) state_nxt = rxd_s ? IDLE : DATA;
      DATA: if (edge_ok) begin
        shift_en = 1'b1;
        if (cnt_inc == nbits) state_nxt = frame_pen ? PARITY : STOP;
      end
      PARITY: if (edge_ok) begin
        par_en    = 1'b1;
        state_nxt = STOP;
      end
      STOP: if (edge_ok) begin
        stop_en   = 1'b1;
        push_nxt  = ~rx_full;
        oe_nxt    = rx_full;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !rx_en) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      push_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rxd_prev       <= 1'b1;
      sample_clk_clr <= 1'b0;
      rx_push        <= 1'b0;
      rx_oe          <= 1'b0;
      rx_data        <= '0;
      rx_pe          <= 1'b0;
      rx_fe          <= 1'b0;
      rx_bi          <= 1'b0;
      frame_wls      <= WLS_5;
      frame_pen      <= 1'b0;
      frame_eps      <= 1'b0;
      frame_sp       <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      par_bit        <= 1'b0;
    end else begin
      rxd_prev       <= rxd_s;
      sample_clk_clr <= clr_nxt;
      rx_push        <= push_nxt;
      rx_oe          <= oe_nxt;
      if (start_frame) begin
        frame_wls <= wls_t'(lcr_wls);
        frame_pen <= lcr_pen;
        frame_eps <= lcr_eps;
        frame_sp  <= lcr_sp;
        shreg     <= '0;
        bit_cnt   <= '0;
        par_bit   <= 1'b0;
      end
      // bits enter at the MSB and are right-justified when the word is pushed
      if (shift_en) begin
        shreg   <= {rxd_s, shreg[DATA_W-1:1]};
        bit_cnt <= cnt_inc;
      end
      if (par_en) par_bit <= rxd_s;
      if (stop_en && push_nxt) begin
        rx_data <= shreg >> (DW_C - nbits);
        rx_pe   <= frame_pen & (par_bit != par_exp);
        rx_fe   <= ~rxd_s;
        rx_bi   <= (shreg == '0) & ~(frame_pen & par_bit) & ~rxd_s;
      end
    end
  end

endmodule
